// File: rtl/math_game_pkg.sv
// Shared types and constants for the math game round controller.
// Holds the FSM state encoding, LED bit positions and the operand-sum helper.
package math_game_pkg;

    localparam int unsigned OPERAND_W = 5;
    localparam int unsigned VALUE_W   = 8;
    localparam int unsigned LED_W     = 7;

    localparam int unsigned LED_SHOW_A  = 0;
    localparam int unsigned LED_SHOW_B  = 1;
    localparam int unsigned LED_WAIT    = 2;
    localparam int unsigned LED_OK      = 3;
    localparam int unsigned LED_BAD     = 4;
    localparam int unsigned LED_TIMEOUT = 5;
    localparam int unsigned LED_OVER    = 6;

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StShowA,
        StShowB,
        StWaitAns,
        StResult,
        StGameOver
    } state_e;

    // Two 5-bit operands always fit in 8 bits (max 62).
    function automatic logic [VALUE_W-1:0] sum_operands(input logic [OPERAND_W-1:0] a,
                                                        input logic [OPERAND_W-1:0] b);
        return VALUE_W'(a) + VALUE_W'(b);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one history flop and an AND gate.
// The reset value of the history flop decides whether a level held through reset counts as an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;
    logic prev_d;

    assign prev_d = sig_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= RESET_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/math_round_ctrl.sv
// Round controller: samples two random operands, shows each, scores the player's sum,
// and after MAX_ROUNDS rounds shows the final score.
module math_round_ctrl
    import math_game_pkg::*;
#(
    parameter int unsigned SHOW_CYCLES   = 1000,
    parameter int unsigned ANSWER_CYCLES = 10000,
    parameter int unsigned RESULT_CYCLES = 1000,
    parameter int unsigned MAX_ROUNDS    = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] rnd_in,
    input  logic                 start,
    input  logic                 submit,
    input  logic [VALUE_W-1:0]   answer,
    output logic [VALUE_W-1:0]   display_value,
    output logic [LED_W-1:0]     led,
    output logic [VALUE_W-1:0]   score,
    output logic                 round_done,
    output logic                 correct
);

    localparam int unsigned MaxAB     = (SHOW_CYCLES > ANSWER_CYCLES) ? SHOW_CYCLES
                                                                      : ANSWER_CYCLES;
    localparam int unsigned MaxCycles = (MaxAB > RESULT_CYCLES) ? MaxAB : RESULT_CYCLES;
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [TimerW-1:0]  ShowLoad   = TimerW'(SHOW_CYCLES - 1);
    localparam logic [TimerW-1:0]  AnswerLoad = TimerW'(ANSWER_CYCLES - 1);
    localparam logic [TimerW-1:0]  ResultLoad = TimerW'(RESULT_CYCLES - 1);
    localparam logic [VALUE_W-1:0] LastRound  = VALUE_W'(MAX_ROUNDS);

    state_e               state_q, state_d;
    logic [TimerW-1:0]    timer_q, timer_d;
    logic [OPERAND_W-1:0] op_a_q, op_a_d;
    logic [OPERAND_W-1:0] op_b_q, op_b_d;
    logic [VALUE_W-1:0]   round_cnt_q, round_cnt_d;
    logic [VALUE_W-1:0]   score_q, score_d;
    logic [VALUE_W-1:0]   display_q, display_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic                 round_done_q, round_done_d;
    logic                 correct_q, correct_d;

    logic                 start_rise;
    logic                 submit_rise;
    logic [VALUE_W-1:0]   expected;
    logic                 scored;
    logic                 verdict;
    logic                 timed_out;

    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_start_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (start),
        .rise_o (start_rise)
    );

    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_submit_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (submit),
        .rise_o (submit_rise)
    );

    assign expected = sum_operands(op_a_q, op_b_q);

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        round_cnt_d  = round_cnt_q;
        score_d      = score_q;
        correct_d    = correct_q;
        round_done_d = 1'b0;
        scored       = 1'b0;
        verdict      = 1'b0;
        timed_out    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    state_d = StLoadA;
                end
            end
            StLoadA: begin
                op_a_d  = rnd_in;
                state_d = StLoadB;
            end
            StLoadB: begin
                op_b_d  = rnd_in;
                state_d = StShowA;
                timer_d = ShowLoad;
            end
            StShowA: begin
                if (timer_q == '0) begin
                    state_d = StShowB;
                    timer_d = ShowLoad;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StShowB: begin
                if (timer_q == '0) begin
                    state_d = StWaitAns;
                    timer_d = AnswerLoad;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StWaitAns: begin
                // Submit is tested first so it wins over expiry in the final cycle.
                if (submit_rise) begin
                    scored  = 1'b1;
                    verdict = (answer == expected);
                end else if (timer_q == '0) begin
                    scored    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
                if (scored) begin
                    state_d      = StResult;
                    timer_d      = ResultLoad;
                    round_done_d = 1'b1;
                    correct_d    = verdict;
                    round_cnt_d  = round_cnt_q + 1'b1;
                    if (verdict && (score_q != '1)) begin
                        score_d = score_q + 1'b1;
                    end
                end
            end
            StResult: begin
                if (timer_q == '0) begin
                    state_d = (round_cnt_q == LastRound) ? StGameOver : StLoadA;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            StGameOver: begin
                if (start_rise) begin
                    score_d     = '0;
                    round_cnt_d = '0;
                    state_d     = StLoadA;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the state being entered so they register on that edge.
    always_comb begin
        display_d = display_q;
        led_d     = '0;

        unique case (state_d)
            StIdle: begin
                display_d = '0;
            end
            StLoadA, StLoadB: begin
                display_d = display_q;
            end
            StShowA: begin
                display_d             = VALUE_W'(op_a_q);
                led_d[LED_SHOW_A]     = 1'b1;
            end
            StShowB: begin
                display_d             = VALUE_W'(op_b_q);
                led_d[LED_SHOW_B]     = 1'b1;
            end
            StWaitAns: begin
                display_d             = answer;
                led_d[LED_WAIT]       = 1'b1;
            end
            StResult: begin
                display_d = expected;
                if (scored) begin
                    led_d[LED_OK]      = verdict;
                    led_d[LED_BAD]     = ~verdict;
                    led_d[LED_TIMEOUT] = timed_out;
                end else begin
                    led_d = led_q;
                end
            end
            StGameOver: begin
                display_d             = score_d;
                led_d[LED_OVER]       = 1'b1;
            end
            default: begin
                display_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            round_cnt_q  <= '0;
            score_q      <= '0;
            display_q    <= '0;
            led_q        <= '0;
            round_done_q <= 1'b0;
            correct_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            round_cnt_q  <= round_cnt_d;
            score_q      <= score_d;
            display_q    <= display_d;
            led_q        <= led_d;
            round_done_q <= round_done_d;
            correct_q    <= correct_d;
        end
    end

    assign display_value = display_q;
    assign led           = led_q;
    assign score         = score_q;
    assign round_done    = round_done_q;
    assign correct       = correct_q;

endmodule

// File: tb/tb_math_round_ctrl.sv
// Directed bench for math_round_ctrl with a scoreboard of expected round verdicts.
// Expectations are queued as each answer is submitted and checked on the round_done pulse.
module tb_math_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rnd_in;
    logic       start;
    logic       submit;
    logic [7:0] answer;
    logic [7:0] display_value;
    logic [6:0] led;
    logic [7:0] score;
    logic       round_done;
    logic       correct;

    typedef struct packed {
        logic       corr;
        logic [7:0] score;
        logic [7:0] disp;
        logic [6:0] led;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    math_round_ctrl #(
        .SHOW_CYCLES   (4),
        .ANSWER_CYCLES (20),
        .RESULT_CYCLES (4),
        .MAX_ROUNDS    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rnd_in        (rnd_in),
        .start         (start),
        .submit        (submit),
        .answer        (answer),
        .display_value (display_value),
        .led           (led),
        .score         (score),
        .round_done    (round_done),
        .correct       (correct)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every round_done pulse must match the oldest queued verdict.
    always @(negedge clk) begin
        exp_t e;
        if (round_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_round_done", 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_correct", correct, e.corr);
                check("rd_score", score, e.score);
                check("rd_display", display_value, e.disp);
                check("rd_led", led, e.led);
            end
        end
    end

    // Precondition: the next edge enters LOAD_A. Returns sampled in the first WAIT_ANS cycle.
    task automatic front(input logic [4:0] a, input logic [4:0] b);
        rnd_in = a;
        tick();
        start = 1'b0;
        tick();
        rnd_in = b;
        tick();
        rnd_in = ~b;
        for (int i = 0; i < 4; i++) begin
            check("show_a_disp", display_value, a);
            check("show_a_led", led, 7'h01);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            check("show_b_disp", display_value, b);
            check("show_b_led", led, 7'h02);
            tick();
        end
        check("wait_led", led, 7'h04);
        check("wait_echo", display_value, answer);
    endtask

    // Remaining RESULT cycles after entry; the next edge leaves RESULT.
    task automatic result_tail(input logic [7:0] disp, input logic [6:0] l, input logic c);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("res_pulse_off", round_done, 1'b0);
            check("res_disp", display_value, disp);
            check("res_led", led, l);
            check("res_correct_held", correct, c);
        end
    endtask

    task automatic wait_19();
        for (int i = 0; i < 19; i++) begin
            tick();
            check("wait_hold_led", led, 7'h04);
        end
    endtask

    task automatic check_game_over(input logic [7:0] s);
        check("over_led", led, 7'h40);
        check("over_disp", display_value, s);
        check("over_score", score, s);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b1;
        submit = 1'b0;
        answer = 8'd0;
        rnd_in = 5'd0;

        // Reset with start held high.
        repeat (3) tick();
        check("rst_disp", display_value, 8'd0);
        check("rst_led", led, 7'd0);
        check("rst_score", score, 8'd0);
        check("rst_round_done", round_done, 1'b0);
        check("rst_correct", correct, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_start_idle", led, 7'd0);
        end
        start = 1'b0;
        tick();

        // Game 1, round 1: correct answer.
        answer = 8'd19;
        start  = 1'b1;
        front(5'd12, 5'd7);
        answer = 8'd3;
        tick();
        check("echo_change", display_value, 8'd3);
        answer = 8'd19;
        submit = 1'b1;
        exp_q.push_back('{corr: 1'b1, score: 8'd1, disp: 8'd19, led: 7'h08});
        tick();
        submit = 1'b0;
        result_tail(8'd19, 7'h08, 1'b1);

        // Game 1, round 2: wrong answer; start held high into GAME_OVER.
        front(5'd20, 5'd9);
        answer = 8'd18;
        submit = 1'b1;
        exp_q.push_back('{corr: 1'b0, score: 8'd1, disp: 8'd29, led: 7'h10});
        tick();
        submit = 1'b0;
        start  = 1'b1;
        result_tail(8'd29, 7'h10, 1'b0);
        tick();
        check_game_over(8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("over_no_restart", led, 7'h40);
        end
        start = 1'b0;
        tick();
        check("over_still", led, 7'h40);

        // Game 2, round 1: submit in the final WAIT_ANS cycle.
        start = 1'b1;
        front(5'd3, 5'd30);
        check("restart_score_clr", score, 8'd0);
        answer = 8'd33;
        wait_19();
        submit = 1'b1;
        exp_q.push_back('{corr: 1'b1, score: 8'd1, disp: 8'd33, led: 7'h08});
        tick();
        submit = 1'b0;
        result_tail(8'd33, 7'h08, 1'b1);

        // Game 2, round 2: timeout even though the switches hold the right sum.
        front(5'd31, 5'd31);
        answer = 8'd62;
        exp_q.push_back('{corr: 1'b0, score: 8'd1, disp: 8'd62, led: 7'h30});
        wait_19();
        tick();
        result_tail(8'd62, 7'h30, 1'b0);
        tick();
        check_game_over(8'd1);

        // Game 3, round 1: correct with zero operands.
        start = 1'b1;
        front(5'd0, 5'd0);
        check("restart2_score_clr", score, 8'd0);
        answer = 8'd0;
        submit = 1'b1;
        exp_q.push_back('{corr: 1'b1, score: 8'd1, disp: 8'd0, led: 7'h08});
        tick();
        submit = 1'b0;
        result_tail(8'd0, 7'h08, 1'b1);

        // Game 3, round 2: reset during WAIT_ANS with submit held high.
        front(5'd5, 5'd6);
        check("pre_rst_score", score, 8'd1);
        answer = 8'd11;
        rst    = 1'b1;
        submit = 1'b1;
        tick();
        check("midrst_disp", display_value, 8'd0);
        check("midrst_led", led, 7'd0);
        check("midrst_score", score, 8'd0);
        check("midrst_correct", correct, 1'b0);
        check("midrst_round_done", round_done, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_led", led, 7'd0);
            check("post_rst_score", score, 8'd0);
            check("post_rst_disp", display_value, 8'd0);
        end
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
